// File: rtl/arm_data_memory_ctrl.sv
// rtl/arm_data_memory_ctrl.sv - word-addressed data RAM with byte lanes, wait states, fault and clear-after-reset
module arm_data_memory_ctrl #(
    parameter int BusWidth     = 32,
    parameter int DataMemSize  = 64,
    parameter int WaitStates   = 1,
    parameter int ClearOnReset = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    input  logic                  i_Req,
    input  logic                  i_Write_Enable,
    input  logic [BusWidth/8-1:0] i_Byte_Enable,
    input  logic [BusWidth-1:0]   i_Address,
    input  logic [BusWidth-1:0]   i_Write_Data,
    output logic [BusWidth-1:0]   o_Read_Data,
    output logic                  o_Ready,
    output logic                  o_Valid,
    output logic                  o_Fault,
    output logic                  o_Busy
);

    localparam int NB = BusWidth / 8;
    localparam int AW = (DataMemSize > 1) ? $clog2(DataMemSize) : 1;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [BusWidth-3:0] word_q;
    logic [BusWidth-1:0] wdata_q;
    logic [NB-1:0]       be_q;
    logic                we_q;
    logic [BusWidth-1:0] rdata_q;
    logic                valid_q;
    logic                fault_q;
    logic [BusWidth-1:0] mem [DataMemSize];

    logic                accept;
    logic                access;
    logic                in_range;
    logic [AW-1:0]       mem_idx;
    logic                unused_addr_bits;

    // Byte offset bits never select anything; the RAM is word-granular.
    assign unused_addr_bits = ^i_Address[1:0];

    assign accept   = i_Req && (state_q == S_IDLE);
    assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign in_range = ({2'b00, word_q} < BusWidth'(DataMemSize));
    assign mem_idx  = word_q[AW-1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DataMemSize - 1)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            S_IDLE: begin
                if (i_Req) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WaitStates);
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q <= (ClearOnReset != 0) ? S_INIT : S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= access;
            fault_q <= access && !in_range;
            if (access && !we_q) begin
                rdata_q <= in_range ? mem[mem_idx] : '0;
            end
        end
    end

    // Request fields are only meaningful once accepted, so they carry no reset.
    always_ff @(posedge i_CLK) begin
        if (accept) begin
            word_q  <= i_Address[BusWidth-1:2];
            wdata_q <= i_Write_Data;
            be_q    <= i_Byte_Enable;
            we_q    <= i_Write_Enable;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RESET) begin
            if (state_q == S_INIT) begin
                mem[idx_q] <= '0;
            end else if (access && we_q && in_range) begin
                for (int k = 0; k < NB; k++) begin
                    if (be_q[k]) begin
                        mem[mem_idx][8*k +: 8] <= wdata_q[8*k +: 8];
                    end
                end
            end
        end
    end

    assign o_Read_Data = rdata_q;
    assign o_Valid     = valid_q;
    assign o_Fault     = fault_q;
    assign o_Ready     = (state_q == S_IDLE);
    assign o_Busy      = (state_q == S_INIT);

endmodule
